// File: rtl/regfile_param_if.sv
// Register-file access bundle: two writeback write ports and NRD packed decode read ports.
// The master drives addresses, enables and write data; the slave returns read data.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] ard;
    logic [NRD*DATA_W-1:0] dout;
    logic                  wren1;
    logic [ADDR_W-1:0]     awr1;
    logic [DATA_W-1:0]     din1;
    logic                  wren2;
    logic [ADDR_W-1:0]     awr2;
    logic [DATA_W-1:0]     din2;

    modport master (output ard, wren1, awr1, din1, wren2, awr2, din2, input dout);
    modport slave  (input ard, wren1, awr1, din1, wren2, awr2, din2, output dout);
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-write / NRD-read register file with port-2 write priority, optional bypass and zero register.
// Latency: writes land on 1 rising edge, reads and bypass are combinational; no backpressure, every write is accepted.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_param_if.slave  rf
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we1_ok;
    logic              we2_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;

    assign we2_ok = rf.wren2 && !((ZERO_REG != 0) && (rf.awr2 == '0));
    // Port 2 owns a colliding address, so port 1 is suppressed outright.
    assign we1_ok = rf.wren1 && !((ZERO_REG != 0) && (rf.awr1 == '0))
                    && !(rf.wren2 && (rf.awr1 == rf.awr2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we1_ok) begin
                mem[rf.awr1] <= rf.din1;
            end
            if (we2_ok) begin
                mem[rf.awr2] <= rf.din2;
            end
        end
    end

    always_comb begin
        rf.dout = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = rf.ard[k*ADDR_W +: ADDR_W];
            rd_val  = mem[rd_addr];
            // Bypass is gated by reset so every read port shows 0 while reset is held.
            if ((BYPASS != 0) && rst_n) begin
                if (rf.wren1 && (rf.awr1 == rd_addr)) begin
                    rd_val = rf.din1;
                end
                if (rf.wren2 && (rf.awr2 == rd_addr)) begin
                    rd_val = rf.din2;
                end
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_val = '0;
            end
            rf.dout[k*DATA_W +: DATA_W] = rd_val;
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// Directed plus randomized check of three regfile_param configurations against an array model.
module tb_regfile_param;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) ifa ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) ifb ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3), .NRD(4)) ifc ();

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1), .ZERO_REG(1))
        ua (.clk(clk), .rst_n(rst_n), .rf(ifa));
    regfile_param #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_REG(0))
        ub (.clk(clk), .rst_n(rst_n), .rf(ifb));
    regfile_param #(.DATA_W(16), .ADDR_W(3), .NRD(4), .BYPASS(1), .ZERO_REG(1))
        uc (.clk(clk), .rst_n(rst_n), .rf(ifc));

    int errors = 0;
    int checks = 0;

    // Stimulus shared by all three instances; the 16-bit one sees truncated address/data.
    logic        w1, w2;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;
    logic [4:0]  ra [2];
    logic [2:0]  rc [4];

    // Reference contents: a = bypass+zero reg, b = plain, c = narrow with zero reg.
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic [15:0] mc [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        foreach (ma[i]) ma[i] = '0;
        foreach (mb[i]) mb[i] = '0;
        foreach (mc[i]) mc[i] = '0;
    endtask

    task automatic drive();
        ifa.wren1 = w1; ifa.awr1 = a1; ifa.din1 = d1;
        ifa.wren2 = w2; ifa.awr2 = a2; ifa.din2 = d2;
        ifb.wren1 = w1; ifb.awr1 = a1; ifb.din1 = d1;
        ifb.wren2 = w2; ifb.awr2 = a2; ifb.din2 = d2;
        ifc.wren1 = w1; ifc.awr1 = a1[2:0]; ifc.din1 = d1[15:0];
        ifc.wren2 = w2; ifc.awr2 = a2[2:0]; ifc.din2 = d2[15:0];
        ifa.ard = {ra[1], ra[0]};
        ifb.ard = {ra[1], ra[0]};
        ifc.ard = {rc[3], rc[2], rc[1], rc[0]};
    endtask

    // What a read port must show, stated directly from the read rules.
    function automatic logic [31:0] rd_model(input logic [31:0] stored, input int addr,
                                             input bit byp, input bit zr, input logic rst,
                                             input logic wa, input int aa, input logic [31:0] da,
                                             input logic wb, input int ab, input logic [31:0] db);
        if (!rst) return '0;
        if (zr && addr == 0) return '0;
        if (byp && wb && ab == addr) return db;
        if (byp && wa && aa == addr) return da;
        return stored;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_a%0d", tag, k), ifa.dout[k*32 +: 32],
                rd_model(ma[ra[k]], int'(ra[k]), 1'b1, 1'b1, rst_n, w1, int'(a1), d1, w2, int'(a2), d2));
            chk($sformatf("%s_b%0d", tag, k), ifb.dout[k*32 +: 32],
                rd_model(mb[ra[k]], int'(ra[k]), 1'b0, 1'b0, rst_n, w1, int'(a1), d1, w2, int'(a2), d2));
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_c%0d", tag, k), {16'h0, ifc.dout[k*16 +: 16]},
                rd_model({16'h0, mc[rc[k]]}, int'(rc[k]), 1'b1, 1'b1, rst_n,
                         w1, int'(a1[2:0]), {16'h0, d1[15:0]}, w2, int'(a2[2:0]), {16'h0, d2[15:0]}));
        end
    endtask

    // Later write wins, so applying port 2 after port 1 gives port-2 priority.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (w1 && a1 != 0) ma[a1] = d1;
            if (w2 && a2 != 0) ma[a2] = d2;
            if (w1) mb[a1] = d1;
            if (w2) mb[a2] = d2;
            if (w1 && a1[2:0] != 0) mc[a1[2:0]] = d1[15:0];
            if (w2 && a2[2:0] != 0) mc[a2[2:0]] = d2[15:0];
        end
        #1;
    endtask

    task automatic idle();
        w1 = 0; w2 = 0; a1 = 0; a2 = 0; d1 = 0; d2 = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_model();
        idle();
        ra[0] = 0; ra[1] = 0;
        foreach (rc[i]) rc[i] = 0;
        drive();
        #2;
        check_all("reset");
        rst_n = 1'b1;
        #1;

        // Reset mid-operation wipes contents; a write on an edge with reset low is dropped.
        w1 = 1; a1 = 5; d1 = 32'hDEAD_BEEF; ra[0] = 5; ra[1] = 5; drive(); #1;
        tick();
        idle(); drive(); #1;
        chk("load5", ifb.dout[31:0], 32'hDEAD_BEEF);
        rst_n = 1'b0; clear_model(); #1;
        chk("rst_imm", ifa.dout[31:0], 32'h0);
        check_all("rst_low");
        w1 = 1; a1 = 5; d1 = 32'h1234_5678; drive(); #1;
        check_all("rst_byp");
        tick();
        idle(); drive(); #1;
        rst_n = 1'b1; #1;
        chk("rst_rel", ifb.dout[31:0], 32'h0);
        check_all("rst_rel");

        // Basic write via port 1, read {16,31}.
        w1 = 1; a1 = 16; d1 = 32'h3; ra[0] = 16; ra[1] = 31; drive(); #1;
        tick();
        idle(); drive(); #1;
        chk("basic_p0", ifa.dout[31:0], 32'h3);
        chk("basic_p1", ifa.dout[63:32], 32'h0);

        // Collision on reg 7: port 2 wins in storage and in bypass.
        w1 = 1; w2 = 1; a1 = 7; a2 = 7; d1 = 32'h1111; d2 = 32'h2222;
        ra[0] = 7; ra[1] = 7; drive(); #1;
        chk("coll_byp", ifa.dout[31:0], 32'h2222);
        check_all("coll_pre");
        tick();
        idle(); drive(); #1;
        chk("coll_a", ifa.dout[63:32], 32'h2222);
        chk("coll_b", ifb.dout[31:0], 32'h2222);

        // Read-during-write on reg 9 with and without bypass.
        w1 = 1; a1 = 9; d1 = 32'hA5A5; ra[0] = 9; ra[1] = 9; drive(); #1;
        chk("byp_pre_a", ifa.dout[31:0], 32'hA5A5);
        chk("byp_pre_b", ifb.dout[31:0], 32'h0);
        tick();
        chk("byp_post_a", ifa.dout[31:0], 32'hA5A5);
        chk("byp_post_b", ifb.dout[31:0], 32'hA5A5);

        // Both ports write reg 0.
        w1 = 1; w2 = 1; a1 = 0; a2 = 0; d1 = 32'hFFFF_FFFF; d2 = 32'hFFFF_FFFF;
        ra[0] = 0; ra[1] = 0; drive(); #1;
        chk("zero_pre_a", ifa.dout[31:0], 32'h0);
        tick();
        idle(); drive(); #1;
        chk("zero_post_a", ifa.dout[31:0], 32'h0);
        chk("zero_post_b", ifb.dout[31:0], 32'hFFFF_FFFF);

        // Narrow 4-read instance: reg 7 and reg 1 in one cycle, read {7,1,7,0}.
        w1 = 1; a1 = 7; d1 = 32'h00AB; w2 = 1; a2 = 1; d2 = 32'h0012;
        rc[0] = 7; rc[1] = 1; rc[2] = 7; rc[3] = 0; drive(); #1;
        tick();
        idle(); drive(); #1;
        chk("c_p0", {16'h0, ifc.dout[15:0]},  32'h00AB);
        chk("c_p1", {16'h0, ifc.dout[31:16]}, 32'h0012);
        chk("c_p2", {16'h0, ifc.dout[47:32]}, 32'h00AB);
        chk("c_p3", {16'h0, ifc.dout[63:48]}, 32'h0000);

        // Random traffic with biased collisions/read hits and one async reset in the middle.
        for (int n = 0; n < 300; n++) begin
            w1 = 1'($urandom_range(0, 1));
            w2 = 1'($urandom_range(0, 1));
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            d1 = $urandom;
            d2 = $urandom;
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 3))
                    0: ra[k] = a1;
                    1: ra[k] = a2;
                    default: ra[k] = 5'($urandom_range(0, 31));
                endcase
            end
            for (int k = 0; k < 4; k++) begin
                rc[k] = ($urandom_range(0, 2) == 0) ? a2[2:0] : 3'($urandom_range(0, 7));
            end
            drive(); #1;
            check_all("rnd_pre");
            if (n == 150) begin
                rst_n = 1'b0; clear_model(); #1;
                check_all("rnd_rst");
                tick();
                rst_n = 1'b1; #1;
            end else begin
                tick();
            end
        end

        // Quiet read-back sweep of every register.
        idle();
        for (int r = 0; r < 32; r++) begin
            ra[0] = 5'(r); ra[1] = 5'(31 - r);
            for (int k = 0; k < 4; k++) rc[k] = 3'(r + k);
            drive(); #1;
            check_all("sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file: the successor to the fixed 32×32, 2-read/1-write register file in the MIPS datapath. It adds configurable data width, address width and read-port count, plus a second write port with deterministic collision priority. It also offers optional write-through bypass, so the decode stage sees same-cycle writeback data, and an optional hardwired zero register. It sits between the writeback stage (write ports) and the decode/ID stage (read ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
- Clk  in  1  clock, all writes on rising edge
- reset  in  1  asynchronous, active-low; clears every register to 0
- Ard  in  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- Dout  out  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- WrEn1  in  1  write enable, port 1
- Awr1  in  ADDR_W  write address, port 1
- Din1  in  DATA_W  write data, port 1
- WrEn2  in  1  write enable, port 2 (priority port)
- Awr2  in  ADDR_W  write address, port 2
- Din2  in  DATA_W  write data, port 2

## Operation
- Storage: 2**ADDR_W × DATA_W flip-flop array; no out-of-range addresses exist.
- Write: at rising Clk with reset high, each enabled port writes its Din to reg[Awr].
- Collision: WrEn1 and WrEn2 both set with Awr1 == Awr2 → only Din2 is stored.
- ZERO_REG=1: writes to address 0 from either port are dropped; reads of address 0 return 0 unconditionally, with no bypass.
- Read: combinational per port, Dout[k] = reg[Ard[k]].
- Bypass (BYPASS=1, reset high): if a port is enabled this cycle with Awr == Ard[k], Dout[k] = that port's Din. Port 2 takes precedence over port 1; ZERO_REG exclusion still applies.
- BYPASS=0: Dout[k] shows the old value until after the edge.
- All read ports are independent; any number may address the same register.

## Timing
- Reset asserted (low), asynchronous: all registers = 0 immediately. Every Dout = 0 while low, since bypass is gated off and writes are ignored.
- Reset deassertion: the first write takes effect on the first rising Clk with reset high.
- Reset asserted between edges mid-operation: contents are lost and no partial write occurs; a write enabled on an edge where reset is low is discarded.
- Write latency: 1 edge. Data is visible on a non-bypassed read immediately after the capturing edge.
- Bypass latency: 0 cycles, purely combinational from Din/Awr/WrEn to Dout within the same cycle.
- No handshake; every enabled write is accepted every cycle, giving 2 writes and NRD reads per cycle.
- Read-during-write to the same address at the edge:
  - BYPASS=1 → Dout shows new data before and after the edge.
  - BYPASS=0 → old data before the edge, new data after.

## Test plan
- Reset: load reg 5 = 32'hDEAD_BEEF, pull reset low between edges → Dout for Ard=5 reads 0 immediately; after release, reads still 0 until rewritten.
- Basic write/read, NRD=2: write 32'h3 to reg 16 via port 1, then Ard={16,31} → Dout = {3, 0} after the edge.
- Collision: WrEn1/WrEn2 both to reg 7 with Din1=32'h1111, Din2=32'h2222 → reg 7 = 32'h2222. Same-cycle bypass read of 7 = 32'h2222.
- Bypass vs. no-bypass: write 32'hA5A5 to reg 9 while Ard=9 (old value 0) → BYPASS=1 gives 32'hA5A5 before the edge; BYPASS=0 gives 0 before the edge and 32'hA5A5 after.
- Zero register: write 32'hFFFF_FFFF to reg 0 via both ports → reg 0 reads 0 in the same cycle and after. With ZERO_REG=0 it reads 32'hFFFF_FFFF after the edge.
- Parametrisation: DATA_W=16, ADDR_W=3, NRD=4 → write 16'h00AB to reg 7 and 16'h0012 to reg 1 in one cycle. Then Ard={7,1,7,0} → Dout={00AB,0012,00AB,0000}.
